// File: rtl/jtframe_romrq_arb_if.sv
// Bus bundle between the romrq slots, the round-robin arbiter and the SDRAM read port.
// The master modport is the arbiter's view; the slave modport is the surrounding system.
interface jtframe_romrq_arb_if #(
    parameter int SDRAMW = 22,
    parameter int N      = 4
);
    logic [N-1:0]        slot_req;
    logic [N*SDRAMW-1:0] slot_addr;
    logic [N-1:0]        slot_we;
    logic [15:0]         slot_din;
    logic                slot_dst;
    logic                slot_din_ok;
    logic                sdram_req;
    logic [SDRAMW-1:0]   sdram_addr;
    logic                sdram_ack;
    logic                sdram_dst;
    logic                sdram_rdy;
    logic [15:0]         sdram_din;

    modport master (
        input  slot_req, slot_addr, sdram_ack, sdram_dst, sdram_rdy, sdram_din,
        output slot_we, slot_din, slot_dst, slot_din_ok, sdram_req, sdram_addr
    );

    modport slave (
        output slot_req, slot_addr, sdram_ack, sdram_dst, sdram_rdy, sdram_din,
        input  slot_we, slot_din, slot_dst, slot_din_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter sharing one SDRAM read port among N romrq slots.
// One committed transaction at a time; read data and strobes are broadcast to every slot.
module jtframe_romrq_arb #(
    parameter int SDRAMW = 22,
    parameter int N      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    jtframe_romrq_arb_if.master  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t              state_r;
    logic [IW-1:0]       sel_r;
    logic [IW-1:0]       last_r;
    logic [N-1:0]        we_r;
    logic                req_r;
    logic [SDRAMW-1:0]   addr_r;
    logic [IW-1:0]       pick_s;
    logic                any_s;
    logic [SDRAMW-1:0]   addr_a_s [N];

    // First requesting slot after the previous winner, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        return {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    // Arbitration decision and per-slot address unpacking.
    always_comb begin
        any_s  = |bus.slot_req;
        pick_s = rr_pick(bus.slot_req, last_r);
        for (int i = 0; i < N; i++) begin
            addr_a_s[i] = bus.slot_addr[i*SDRAMW +: SDRAMW];
        end
    end

    // Transaction sequencer; the grant is committed until the burst has ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sel_r   <= {IW{1'b0}};
            last_r  <= IW'(N-1);
            we_r    <= {N{1'b0}};
            req_r   <= 1'b0;
            addr_r  <= {SDRAMW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        sel_r   <= pick_s;
                        last_r  <= pick_s;
                        addr_r  <= addr_a_s[pick_s];
                        req_r   <= 1'b1;
                        state_r <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.sdram_ack) begin
                        req_r   <= 1'b0;
                        we_r    <= onehot(sel_r);
                        // a single-word burst ending with the ack still gets one we cycle, in GAP
                        state_r <= bus.sdram_rdy ? GAP : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (bus.sdram_rdy) begin
                        we_r    <= {N{1'b0}};
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    we_r    <= {N{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    we_r    <= {N{1'b0}};
                    req_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.slot_we     = we_r;
    assign bus.sdram_req   = req_r;
    assign bus.sdram_addr  = addr_r;
    assign bus.slot_din    = bus.sdram_din;
    assign bus.slot_dst    = bus.sdram_dst;
    assign bus.slot_din_ok = bus.sdram_rdy;
endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Bench for jtframe_romrq_arb: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_jtframe_romrq_arb;
    localparam int NS = 4;
    localparam int W  = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    jtframe_romrq_arb_if #(.SDRAMW(W), .N(NS)) bus ();
    jtframe_romrq_arb #(.SDRAMW(W), .N(NS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // transaction-level model
    int          m_owner, m_last, m_cool, m_wecyc;
    bit          m_acked;
    logic [3:0]  m_we;
    logic        m_req;
    logic [21:0] m_addr;
    int          m_grants[$];

    // bench-side SDRAM responder
    int          r_phase, r_cnt, r_blen, r_word;
    int          ack_dly, blen;
    bit          rand_mode, drop_mode;
    logic [15:0] drv_din;
    logic        drv_dst, drv_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] req, input int last);
        for (int k = 1; k <= NS; k++)
            if (req[(last + k) % NS]) return (last + k) % NS;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = NS - 1; m_cool = 0; m_acked = 0;
        m_we = 4'd0; m_req = 1'b0; m_addr = 22'd0;
    endtask

    task automatic model_update();
        int g;
        if (rst) model_reset();
        else if (m_owner < 0 && m_cool == 0) begin
            if (bus.slot_req != 4'd0) begin
                g = rr(bus.slot_req, m_last);
                m_owner = g; m_last = g; m_acked = 0; m_req = 1'b1;
                m_addr = bus.slot_addr[g*W +: W];
                m_grants.push_back(g);
            end
        end else if (m_owner >= 0 && !m_acked) begin
            if (bus.sdram_ack) begin
                m_req = 1'b0;
                m_we  = 4'd1 << m_owner;
                if (bus.sdram_rdy) begin m_owner = -1; m_cool = 1; end
                else m_acked = 1;
            end
        end else if (m_owner >= 0) begin
            if (bus.sdram_rdy) begin m_we = 4'd0; m_owner = -1; m_cool = 1; end
        end else begin
            m_cool = 0; m_we = 4'd0;
        end
    endtask

    task automatic check_all();
        chk("slot_we", bus.slot_we, m_we);
        chk("sdram_req", bus.sdram_req, m_req);
        chk("sdram_addr", bus.sdram_addr, m_addr);
        chk("slot_din", bus.slot_din, drv_din);
        chk("slot_dst", bus.slot_dst, drv_dst);
        chk("slot_din_ok", bus.slot_din_ok, drv_rdy);
        chk("we_onehot0", $onehot0(bus.slot_we), 1);
        if (m_we != 4'd0) m_wecyc++;
    endtask

    task automatic drive_resp();
        logic a, d, r;
        a = 1'b0; d = 1'b0; r = 1'b0;
        if (r_phase == 0 && bus.sdram_req) begin
            r_phase = 1;
            r_cnt  = rand_mode ? $urandom_range(0, 3) : ack_dly;
            r_blen = rand_mode ? $urandom_range(0, 4) : blen;
            if (drop_mode) bus.slot_req = 4'd0;
        end
        if (r_phase == 1) begin
            if (r_cnt == 0) begin
                a = 1'b1;
                if (r_blen == 0) begin d = 1'b1; r = 1'b1; r_phase = 0; end
                else begin r_phase = 2; r_word = 0; if (rand_mode) d = ($urandom_range(0, 3) == 0); end
            end else r_cnt--;
        end else if (r_phase == 2) begin
            r_word++;
            d = (r_word == 1);
            r = (r_word == r_blen);
            if (r) r_phase = 0;
        end
        if (rand_mode && !a && r_phase != 2 && !r) begin
            d = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 7) == 0);
        end
        drv_din = 16'($urandom);
        drv_dst = d; drv_rdy = r;
        bus.sdram_ack = a; bus.sdram_dst = d; bus.sdram_rdy = r; bus.sdram_din = drv_din;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
        drive_resp();
    endtask

    task automatic run_txn(input logic [3:0] req, input int n, input int ad, input int bl, input bit drop);
        int base;
        bit done;
        bus.slot_req = req; ack_dly = ad; blen = bl; drop_mode = drop;
        base = m_grants.size(); done = 1'b0;
        for (int c = 0; c < 60 * n && !done; c++) begin
            tick();
            if (m_grants.size() >= base + n && m_owner < 0 && m_cool == 0) done = 1'b1;
        end
        chk("txn_done", done, 1);
        bus.slot_req = 4'd0; drop_mode = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        model_reset();
        r_phase = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp2[5];
        int base;
        bit seen;
        exp2 = '{0, 1, 2, 3, 0};
        bus.slot_req = 4'd0; bus.sdram_ack = 1'b0; bus.sdram_dst = 1'b0; bus.sdram_rdy = 1'b0;
        bus.sdram_din = 16'd0; drv_din = 16'd0; drv_dst = 1'b0; drv_rdy = 1'b0;
        for (int i = 0; i < NS; i++) bus.slot_addr[i*W +: W] = 22'($urandom);
        rand_mode = 1'b0; drop_mode = 1'b0; r_phase = 0; ack_dly = 0; blen = 1; m_wecyc = 0;
        model_reset();
        reset_pulse();
        chk("reset_we", bus.slot_we, 4'd0);
        chk("reset_req", bus.sdram_req, 1'b0);
        chk("reset_addr", bus.sdram_addr, 22'd0);

        // single request, ack 3 clk after req, dst then rdy
        bus.slot_addr[0 +: W] = 22'h12345;
        m_wecyc = 0;
        run_txn(4'b0001, 1, 2, 2, 1'b0);
        chk("t1_grant", m_grants[m_grants.size()-1], 0);
        chk("t1_we_cycles", m_wecyc, 2);
        chk("t1_addr", bus.sdram_addr, 22'h12345);

        // round-robin with all slots requesting, from reset
        reset_pulse();
        base = m_grants.size();
        run_txn(4'b1111, 5, 0, 2, 1'b0);
        for (int k = 0; k < 5; k++) chk("t2_order", m_grants[base+k], exp2[k]);

        // wrap and skip: last=2, then 0011
        run_txn(4'b0100, 1, 1, 1, 1'b0);
        base = m_grants.size();
        run_txn(4'b0011, 2, 1, 1, 1'b0);
        chk("t3_first", m_grants[base], 0);
        chk("t3_second", m_grants[base+1], 1);

        // ack and rdy in the same cycle
        m_wecyc = 0;
        run_txn(4'b1000, 1, 0, 0, 1'b0);
        chk("t4_grant", m_grants[m_grants.size()-1], 3);
        chk("t4_we_cycles", m_wecyc, 1);

        // requester drops during WAIT_ACK
        m_wecyc = 0;
        run_txn(4'b0010, 1, 3, 2, 1'b1);
        chk("t5_grant", m_grants[m_grants.size()-1], 1);
        chk("t5_we_cycles", m_wecyc, 2);

        // reset in the middle of WAIT_DATA
        bus.slot_req = 4'b1111; ack_dly = 0; blen = 4;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (m_we != 4'd0) seen = 1'b1;
        end
        chk("t6_in_data", seen, 1);
        chk("t6_grant_before", m_grants[m_grants.size()-1], 2);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_async_we", bus.slot_we, 4'd0);
        chk("t6_async_req", bus.sdram_req, 1'b0);
        chk("t6_async_addr", bus.sdram_addr, 22'd0);
        model_reset();
        r_phase = 0;
        tick(); tick();
        rst = 1'b0;
        run_txn(4'b1111, 1, 1, 2, 1'b0);
        chk("t6_grant_after", m_grants[m_grants.size()-1], 0);

        // random traffic
        rand_mode = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 3) == 0) bus.slot_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) bus.slot_addr[$urandom_range(0, NS-1)*W +: W] = 22'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
